// File: rtl/eq_pkg.sv
// rtl/eq_pkg.sv - shared equalizer constants: LMS state encoding, slicer level, unity coefficient
package eq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_DD    = 2'd2,
    ST_HOLD  = 2'd3
  } lms_state_e;

  localparam int SLICE_LVL = 64;

  // 1.0 in S(coef_bw, coef_bw-2) format
  function automatic int unity_coef(input int coef_bw);
    return 1 << (coef_bw - 2);
  endfunction

endpackage

// File: rtl/lms_tap_acc.sv
// rtl/lms_tap_acc.sv - single-tap LMS accumulator: multiply, shift, saturate, optional leak (LMS_LEAKAGE_EN)
module lms_tap_acc
  import eq_pkg::*;
#(
  parameter int DATA_BW    = 11,
  parameter int COEF_BW    = 9,
  parameter int FRAC_BW    = 12,
  parameter int SH_BW      = 4,
  parameter int LEAK_SHIFT = 10,
  parameter logic [COEF_BW+FRAC_BW-1:0] INIT_VAL = '0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_clear,
  input  logic                      i_upd,
  input  logic signed [COEF_BW:0]   i_err,
  input  logic signed [DATA_BW-1:0] i_x,
  input  logic [SH_BW-1:0]          i_shift,
  output logic [COEF_BW-1:0]        o_coef,
  output logic                      o_sat
);

  localparam int ACC_BW  = COEF_BW + FRAC_BW;
  localparam int PROD_BW = COEF_BW + 1 + DATA_BW;
  localparam int WIDE_BW = (ACC_BW > PROD_BW) ? ACC_BW : PROD_BW;
  localparam int SUM_BW  = WIDE_BW + 2;

  localparam logic signed [SUM_BW-1:0] SUM_MAX =
    {{(SUM_BW-ACC_BW+1){1'b0}}, {(ACC_BW-1){1'b1}}};
  localparam logic signed [SUM_BW-1:0] SUM_MIN =
    {{(SUM_BW-ACC_BW+1){1'b1}}, {(ACC_BW-1){1'b0}}};

`ifdef LMS_LEAKAGE_EN
  localparam bit LEAK_EN = 1'b1;
`else
  localparam bit LEAK_EN = 1'b0;
`endif

  logic signed [ACC_BW-1:0]  acc_q, acc_d;
  logic signed [PROD_BW-1:0] prod, prod_sh;
  logic signed [SUM_BW-1:0]  leak, sum;

  assign prod    = PROD_BW'(i_err) * PROD_BW'(i_x);
  assign prod_sh = prod >>> i_shift;
  assign leak    = LEAK_EN ? SUM_BW'(acc_q >>> LEAK_SHIFT) : '0;
  assign sum     = SUM_BW'(acc_q) + SUM_BW'(prod_sh) - leak;

  always_comb begin
    acc_d = acc_q;
    o_sat = 1'b0;
    if (i_clear) begin
      acc_d = INIT_VAL;
    end else if (i_upd) begin
      if (sum > SUM_MAX) begin
        acc_d = SUM_MAX[ACC_BW-1:0];
        o_sat = 1'b1;
      end else if (sum < SUM_MIN) begin
        acc_d = SUM_MIN[ACC_BW-1:0];
        o_sat = 1'b1;
      end else begin
        acc_d = sum[ACC_BW-1:0];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) acc_q <= INIT_VAL;
    else          acc_q <= acc_d;
  end

  assign o_coef = acc_q[ACC_BW-1 -: COEF_BW];

endmodule

// File: rtl/lms_coef_update.sv
// rtl/lms_coef_update.sv - LMS coefficient engine for the FFE; optional leakage via LMS_LEAKAGE_EN
module lms_coef_update
  import eq_pkg::*;
#(
  parameter int DATA_BW    = 11,
  parameter int COEF_BW    = 9,
  parameter int N_COEF     = 7,
  parameter int FRAC_BW    = 12,
  parameter int CENTER     = 3,
  parameter int SLICE      = SLICE_LVL,
  parameter int MU_BASE    = 6,
  parameter int TRAIN_LEN  = 1024,
  parameter int LEAK_SHIFT = 10
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_en,
  input  logic [DATA_BW-1:0]        i_data,
  input  logic [COEF_BW-1:0]        i_ffe_out,
  input  logic [COEF_BW-1:0]        i_ref,
  input  logic                      i_start,
  input  logic                      i_clear,
  input  logic                      i_freeze,
  input  logic [1:0]                i_mu_sel,
  output logic [COEF_BW*N_COEF-1:0] o_coefs,
  output logic [COEF_BW:0]          o_error,
  output logic [1:0]                o_state,
  output logic                      o_sat
);

  localparam int ACC_BW = COEF_BW + FRAC_BW;
  localparam int SH_BW  = $clog2(MU_BASE + 4);
  localparam int CNT_BW = $clog2(TRAIN_LEN + 1);
  localparam logic [CNT_BW-1:0] CNT_END = CNT_BW'(TRAIN_LEN);
  localparam logic signed [COEF_BW-1:0] SLICE_POS = COEF_BW'(SLICE);
  localparam logic signed [COEF_BW-1:0] SLICE_NEG = -SLICE_POS;

  lms_state_e state_q, state_d, saved_q, saved_d, eff_mode, mode_next;
  logic [CNT_BW-1:0]         cnt_q, cnt_d, cnt_next;
  logic signed [DATA_BW-1:0] hist_q [1:N_COEF-1];
  logic signed [DATA_BW-1:0] hist_d [1:N_COEF-1];
  logic signed [DATA_BW-1:0] x [0:N_COEF-1];
  logic signed [COEF_BW-1:0] dec;
  logic signed [COEF_BW:0]   err, err_q;
  logic                      active, upd, sat_q, sat_d;
  logic [N_COEF-1:0]         tap_sat;
  logic [SH_BW-1:0]          shift;

  // A pending i_start overrides the mode; HOLD resumes its saved mode once i_freeze drops
  always_comb begin
    eff_mode = state_q;
    if (i_start)                   eff_mode = ST_TRAIN;
    else if (state_q == ST_HOLD)   eff_mode = saved_q;
  end

  assign active = (eff_mode == ST_TRAIN) || (eff_mode == ST_DD);
  assign upd    = i_en && !i_clear && active && (i_start || !i_freeze);
  assign shift  = SH_BW'(MU_BASE) + SH_BW'(i_mu_sel);

  always_comb begin
    dec = i_ffe_out[COEF_BW-1] ? SLICE_NEG : SLICE_POS;
    if (eff_mode == ST_TRAIN) dec = i_ref;
  end

  assign err = {dec[COEF_BW-1], dec} - {i_ffe_out[COEF_BW-1], i_ffe_out};

  always_comb begin
    x[0] = i_data;
    for (int k = 1; k < N_COEF; k++) x[k] = hist_q[k];
    hist_d = hist_q;
    if (i_en) begin
      hist_d[1] = i_data;
      for (int k = 2; k < N_COEF; k++) hist_d[k] = hist_q[k-1];
    end
  end

  always_comb begin
    state_d   = state_q;
    saved_d   = saved_q;
    cnt_d     = cnt_q;
    cnt_next  = cnt_q;
    mode_next = eff_mode;
    if (i_clear) begin
      state_d = state_q;
    end else if (i_start) begin
      state_d = ST_TRAIN;
      cnt_d   = upd ? CNT_BW'(1) : '0;
    end else if (state_q != ST_IDLE) begin
      if (upd && eff_mode == ST_TRAIN && cnt_q < CNT_END) cnt_next = cnt_q + 1'b1;
      cnt_d = cnt_next;
      if (eff_mode == ST_TRAIN && cnt_next >= CNT_END) mode_next = ST_DD;
      if (i_freeze) begin
        state_d = ST_HOLD;
        saved_d = mode_next;
      end else begin
        state_d = mode_next;
      end
    end
  end

  always_comb begin
    sat_d = sat_q | (|tap_sat);
    if (i_clear) sat_d = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      saved_q <= ST_TRAIN;
      cnt_q   <= '0;
      err_q   <= '0;
      sat_q   <= 1'b0;
      for (int k = 1; k < N_COEF; k++) hist_q[k] <= '0;
    end else begin
      state_q <= state_d;
      saved_q <= saved_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      hist_q  <= hist_d;
      if (i_en && active) err_q <= err;
    end
  end

  for (genvar j = 0; j < N_COEF; j++) begin : g_tap
    localparam logic [ACC_BW-1:0] INIT =
      (j == CENTER) ? (ACC_BW'(unity_coef(COEF_BW)) << FRAC_BW) : '0;

    lms_tap_acc #(
      .DATA_BW    (DATA_BW),
      .COEF_BW    (COEF_BW),
      .FRAC_BW    (FRAC_BW),
      .SH_BW      (SH_BW),
      .LEAK_SHIFT (LEAK_SHIFT),
      .INIT_VAL   (INIT)
    ) u_tap (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_clear (i_clear),
      .i_upd   (upd),
      .i_err   (err),
      .i_x     (x[j]),
      .i_shift (shift),
      .o_coef  (o_coefs[COEF_BW*j +: COEF_BW]),
      .o_sat   (tap_sat[j])
    );
  end

  assign o_error = err_q;
  assign o_state = state_q;
  assign o_sat   = sat_q;

endmodule

// File: doc/lms_coef_update.md
# lms_coef_update

Adaptive coefficient engine for the feed-forward equalizer. Observes the same input samples as the FFE together with the FFE's output, forms an error against a training reference or a 2-PAM slicer decision, and updates N_COEF tap coefficients with sign-preserving LMS. It drives the FFE coefficient bus, closing the adaptation loop.

## Interface
- DATA_BW, 11, input sample width; signed
- COEF_BW, 9, coefficient and FFE output width; signed S(COEF_BW, COEF_BW-2), so 1.0 = 128 for 9 bits
- N_COEF, 7, number of taps
- FRAC_BW, 12, extra accumulator fraction bits; ACC_BW = COEF_BW+FRAC_BW
- CENTER, 3, index of the tap initialised to 1.0
- SLICE_LVL, 64, 2-PAM decision magnitude in FFE output units
- MU_BASE, 6, base right-shift of the update term
- TRAIN_LEN, 1024, number of updates spent in TRAIN before DD
- LEAK_SHIFT, 10, leakage shift; used only with the leakage macro
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_en  in  1  sample strobe; same strobe that enables the FFE
- i_data  in  DATA_BW  sample presented to the FFE this strobe
- i_ffe_out  in  COEF_BW  FFE output for this strobe; combinational, same cycle
- i_ref  in  COEF_BW  training symbol; used in TRAIN only
- i_start  in  1  pulse: enter TRAIN and clear the training counter
- i_clear  in  1  pulse: reload reset coefficients
- i_freeze  in  1  level: hold coefficients
- i_mu_sel  in  2  extra step shift; total shift = MU_BASE+i_mu_sel
- o_coefs  out  COEF_BW*N_COEF  coefficient bus, C0 at LSBs; C_j in bits [COEF_BW*(j+1)-1 : COEF_BW*j]
- o_error  out  COEF_BW+1  registered last error
- o_state  out  2  IDLE=0, TRAIN=1, DD=2, HOLD=3
- o_sat  out  1  sticky flag; set when any accumulator saturates

## Operation
- Regressor delay line x[0..N_COEF-1]:
  - x[0] = i_data, combinational.
  - x[1..N_COEF-1] = registered history, shifted on i_en.
- Decision d:
  - TRAIN: d = i_ref.
  - DD: d = +SLICE_LVL if i_ffe_out ≥ 0, else −SLICE_LVL.
- Error: e = d − i_ffe_out, COEF_BW+1 bits, exact.
- Update (on i_en, in TRAIN/DD only), for each j:
  - acc_j += (e·x[j]) >>> (MU_BASE+i_mu_sel), arithmetic shift.
  - Sum is saturated to the ACC_BW signed range; saturation sets o_sat.
- Coefficient output: C_j = acc_j[ACC_BW-1 -: COEF_BW], truncation.
- Accumulator reset value:
  - All zero, except acc_CENTER = 2^(COEF_BW-2) << FRAC_BW.
- FSM:
  - IDLE → TRAIN on i_start.
  - TRAIN → DD when the update counter reaches TRAIN_LEN.
  - TRAIN/DD → HOLD while i_freeze; HOLD → saved mode (TRAIN or DD) when i_freeze drops.
  - i_start from any state → TRAIN, counter = 0; accumulators are kept.
- Priority: reset > i_clear > i_start > i_freeze > counter expiry.
- i_clear reloads the accumulator reset values and clears o_sat. State is unchanged.
- Delay line shifts on i_en in every state, so the regressor is already aligned when updates resume.

## Timing
- Reset: o_coefs = center tap 1.0, others 0; o_error = 0; o_state = IDLE; o_sat = 0; delay line and counter = 0.
- Latency:
  - e and the update are computed in the i_en cycle.
  - New o_coefs are visible from the next cycle, i.e. effective for the next FFE sample.
  - o_error is registered on i_en and valid the cycle after.
- Cycles with i_en = 0: no register changes except FSM transitions on i_start, i_clear and i_freeze.
- Counter increments only on update strobes. Expiry and i_freeze in the same cycle → HOLD, with DD saved as the resume mode.
- i_start and i_en in the same cycle: that strobe performs a TRAIN update, and the counter becomes 1.
- Reset asserted mid-adaptation: all state returns to reset values at that edge.

## Configuration
- LMS_LEAKAGE_EN defined:
  - Each update also subtracts acc_j >>> LEAK_SHIFT, before saturation.
  - Prevents coefficient drift in DD mode.
- LMS_LEAKAGE_EN undefined: plain LMS. LEAK_SHIFT is ignored.

## Structure
- Shared package `eq_pkg` holds:
  - state encoding constants (IDLE/TRAIN/DD/HOLD);
  - the 2-PAM slicer level;
  - the unity-coefficient constant 2^(COEF_BW-2).
- One sub-module, `lms_tap_acc`: a single-tap accumulator with multiply, shift, saturate and optional leak, instantiated N_COEF times.

## Test plan
- Reset release, no i_start, 10 strobes: o_coefs bus C3 = 128, others 0; o_state = 0; o_error = 0.
- i_start, then i_ref = 64 and i_ffe_out = 0 on every strobe, i_data = 100, i_mu_sel = 0:
  - e = 64; each acc_j += 6400>>>6 = 100 per strobe;
  - after 41 strobes C0 rises from 0 to 1 (truncation boundary).
- TRAIN_LEN overridden to 4, then 4 updates: o_state goes TRAIN→DD. Next strobe with i_ffe_out = −5 → d = −64, o_error = −59.
- i_freeze asserted in DD for 20 strobes: coefficients are bit-identical. Deassert → o_state = DD, and updates resume on the first strobe.
- Drive e = 64 with i_data = 1023, i_mu_sel = 0, until saturation: acc clamps at the max, C_j = 255, o_sat = 1. Then i_clear → reset coefficients and o_sat = 0.
- With LMS_LEAKAGE_EN, i_ffe_out = d (e = 0) for 2000 strobes: C_CENTER decays below 128. Without the macro it stays at 128.
